reaction_core_multi: RTL
========================

Name: reaction_core_multi

Overview:
- Parametrised reaction-game controller for NUM_PLAYERS contestants.
- Combines input synchronisation and debounce, a pseudo-random arm delay, a millisecond reaction counter, early-press (foul) detection, winner arbitration and best-time tracking.
- Sits between the board buttons and the display path: drives the 14-bit value and the state code that the seven-segment display block renders.
- Replaces the fixed single-player game logic.

Parameters:
- CLK_HZ, 100000000, input clock frequency.
- TICK_HZ, 1000, counting unit rate (1 ms); CLK_HZ/TICK_HZ must be an integer >= 1.
- NUM_PLAYERS, 2, number of react buttons (1..8).
- DEB_TICKS, 10, consecutive ticks a raw input must be stable before the debounced level changes.
- MIN_WAIT, 1000, minimum arm delay in ticks.
- WAIT_SPAN_W, 11, random extra delay = LFSR[WAIT_SPAN_W-1:0] ticks.
- LFSR_SEED, 16'hACE1, non-zero reset value of the 16-bit LFSR.
- MAX_COUNT, 9999, reaction counter saturation value and "no best" sentinel.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- btn_start  in  1  raw start button, asynchronous
- btn_react  in  NUM_PLAYERS  raw react buttons, asynchronous
- btn_clear  in  1  raw clear-best button, asynchronous
- number  out  14  value to display
- mode  out  3  state code: 0 IDLE, 1 WAIT, 2 GO, 3 DONE, 4 FOUL
- winner  out  3  index of the deciding player
- winner_valid  out  1  high in DONE/FOUL when a player decided the round
- new_best  out  1  one-cycle pulse when the best time is updated

Behaviour:
- Reset is asynchronous and active-low: rst=0 forces all flops immediately.
  - Reset values: state=IDLE, number=MAX_COUNT, mode=0, winner=0, winner_valid=0, new_best=0, best=MAX_COUNT, LFSR=LFSR_SEED, all counters=0.
  - Debounced levels reset to 0.
  - Reset asserted mid-round aborts the round; no best-time update occurs.
- Tick: a prescaler counts 0..CLK_HZ/TICK_HZ-1 and emits tick_en for one clk on wrap. When CLK_HZ==TICK_HZ, tick_en=1 every cycle.
- Input path, per button:
  - 2-flop synchroniser.
  - Debouncer: the level changes only after DEB_TICKS consecutive ticks of stable differing input.
  - Press event = rising edge of the debounced level, one clk wide.
  - Holding a button produces no repeat events.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every clk in every state.
- FSM, evaluated on press events in the clk after the event:
  - IDLE:
    - number=best.
    - clear event -> best=MAX_COUNT.
    - start event -> WAIT; load wait_cnt = MIN_WAIT + LFSR[WAIT_SPAN_W-1:0] sampled that cycle.
  - WAIT:
    - number=0; wait_cnt decrements on tick_en.
    - Any react event -> FOUL, winner = lowest index pressing, winner_valid=1.
    - wait_cnt reaching 0 with no react -> GO, react_cnt=0.
    - React beats expiry if both occur in the same clk.
  - GO:
    - number=react_cnt; react_cnt increments on tick_en and saturates at MAX_COUNT.
    - First react event -> DONE, result=react_cnt in the same clk, winner = lowest pressing index, winner_valid=1.
    - react_cnt reaching MAX_COUNT -> DONE with winner_valid=0.
    - Start and clear events are ignored.
  - DONE:
    - number=result.
    - On entry, if winner_valid and result<best: best=result and new_best pulses for 1 clk.
    - Start event -> WAIT (new round, same load rule).
    - Clear event -> best=MAX_COUNT.
  - FOUL:
    - number=MAX_COUNT.
    - Start event -> WAIT. No best update.
- Reaction times include the fixed synchroniser and debounce latency; no compensation is applied.
- Simultaneous start and react events: react takes priority in WAIT/GO; start takes priority in DONE/FOUL.
- mode and number are registered: they change 1 clk after the state transition.
- winner holds its value until the next WAIT entry, where it clears to 0.

Test Plan:
(Bench parameters: CLK_HZ=TICK_HZ=1000, DEB_TICKS=2, MIN_WAIT=4, WAIT_SPAN_W=2, NUM_PLAYERS=2; the bench models the LFSR.)
- Reset: hold rst=0 with buttons toggling -> number=9999, mode=0, winner_valid=0. Release, then press start for 6 clk -> mode=1 after sync+debounce+1 clk, with wait_cnt = 4 + model LFSR[1:0].
- Normal round: start; after GO entry, press react[1] 7 cycles later -> mode=3, number=7+debounce/sync latency, winner=1, winner_valid=1, new_best pulses once, best updated.
- Foul: start, press react[0] during WAIT -> mode=4, number=9999, winner=0, best unchanged, no new_best.
- Tie: react[0] and react[1] rise in the same clk during GO -> winner=0. A slower second round -> no new_best, best keeps the lower value.
- Timeout: no react during GO -> react_cnt stops at 9999, mode=3, winner_valid=0, best unchanged. Clear then moves best to 9999 and IDLE shows 9999.
- Bounce and reset mid-round: 1-tick glitches on btn_start produce no event. Asserting rst in GO -> immediate reset values, LFSR reloads the seed.

Source files
------------

// File: rtl/reaction_core_multi.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reaction_core_multi : multi-player reaction game (debounce, arm delay, timing)
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module reaction_core_multi #(
  parameter int          CLK_HZ      = 100000000,
  parameter int          TICK_HZ     = 1000,
  parameter int          NUM_PLAYERS = 2,
  parameter int          DEB_TICKS   = 10,
  parameter int          MIN_WAIT    = 1000,
  parameter int          WAIT_SPAN_W = 11,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          MAX_COUNT   = 9999
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn_start,
  input  logic [NUM_PLAYERS-1:0] btn_react,
  input  logic                   btn_clear,
  output logic [13:0]            number,
  output logic [2:0]             mode,
  output logic [2:0]             winner,
  output logic                   winner_valid,
  output logic                   new_best
);

  localparam int          DIV   = CLK_HZ / TICK_HZ;
  localparam int          PW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int          NB    = NUM_PLAYERS + 2;
  localparam int          DW    = $clog2(DEB_TICKS + 1);
  localparam int          WW    = $clog2(MIN_WAIT + (1 << WAIT_SPAN_W)) + 1;
  localparam logic [13:0] C_MAX = 14'(MAX_COUNT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_GO   = 3'd2,
    S_DONE = 3'd3,
    S_FOUL = 3'd4
  } state_t;

  logic w_tick;

  generate
    if (DIV <= 1) begin : g_tick_every_clk
      assign w_tick = 1'b1;
    end else begin : g_prescaler
      logic [PW-1:0] r_presc;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_presc <= '0;
        end else if (r_presc == PW'(DIV - 1)) begin
          r_presc <= '0;
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end
      assign w_tick = (r_presc == PW'(DIV - 1));
    end
  endgenerate

  // Button vector: bit 0 start, bits 1..NUM_PLAYERS react, top bit clear.
  logic [NB-1:0] w_raw;
  logic [NB-1:0] r_s1, r_s2, r_lvl, r_lvl_d;
  logic [DW-1:0] r_deb [NB];
  logic [NB-1:0] w_press;

  assign w_raw = {btn_clear, btn_react, btn_start};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_lvl   <= '0;
      r_lvl_d <= '0;
      for (int i = 0; i < NB; i++) r_deb[i] <= '0;
    end else begin
      r_s1    <= w_raw;
      r_s2    <= r_s1;
      r_lvl_d <= r_lvl;
      for (int i = 0; i < NB; i++) begin
        if (r_s2[i] == r_lvl[i]) begin
          r_deb[i] <= '0;
        end else if (w_tick) begin
          if (r_deb[i] == DW'(DEB_TICKS - 1)) begin
            r_lvl[i] <= r_s2[i];
            r_deb[i] <= '0;
          end else begin
            r_deb[i] <= r_deb[i] + 1'b1;
          end
        end
      end
    end
  end

  assign w_press = r_lvl & ~r_lvl_d;

  logic                   w_start, w_clear;
  logic [NUM_PLAYERS-1:0] w_react;
  logic [2:0]             w_first;

  assign w_start = w_press[0];
  assign w_react = w_press[NUM_PLAYERS:1];
  assign w_clear = w_press[NB-1];

  // Lowest pressing index wins ties.
  always_comb begin
    w_first = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (w_react[i]) w_first = 3'(i);
    end
  end

  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  state_t        r_state;
  logic [WW-1:0] r_wait;
  logic [13:0]   r_react_cnt, r_result, r_best;
  logic [2:0]    r_win_idx;
  logic          r_win_vld, r_nb_pend;
  logic [WW-1:0] w_wait_load;

  assign w_wait_load = WW'(MIN_WAIT) + WW'(r_lfsr[WAIT_SPAN_W-1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_wait      <= '0;
      r_react_cnt <= '0;
      r_result    <= '0;
      r_best      <= C_MAX;
      r_win_idx   <= '0;
      r_win_vld   <= 1'b0;
      r_nb_pend   <= 1'b0;
    end else begin
      r_nb_pend <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_clear) r_best <= C_MAX;
          if (w_start) begin
            r_state   <= S_WAIT;
            r_wait    <= w_wait_load;
            r_win_idx <= '0;
            r_win_vld <= 1'b0;
          end
        end
        S_WAIT: begin
          if (|w_react) begin
            r_state   <= S_FOUL;
            r_win_idx <= w_first;
            r_win_vld <= 1'b1;
          end else if (w_tick) begin
            if (r_wait <= WW'(1)) begin
              r_state     <= S_GO;
              r_react_cnt <= '0;
            end else begin
              r_wait <= r_wait - 1'b1;
            end
          end
        end
        S_GO: begin
          if (|w_react) begin
            r_state   <= S_DONE;
            r_result  <= r_react_cnt;
            r_win_idx <= w_first;
            r_win_vld <= 1'b1;
            if (r_react_cnt < r_best) begin
              r_best    <= r_react_cnt;
              r_nb_pend <= 1'b1;
            end
          end else if (w_tick) begin
            if (r_react_cnt >= C_MAX - 14'd1) begin
              r_react_cnt <= C_MAX;
              r_result    <= C_MAX;
              r_state     <= S_DONE;
            end else begin
              r_react_cnt <= r_react_cnt + 14'd1;
            end
          end
        end
        S_FOUL: begin
          if (w_start) begin
            r_state   <= S_WAIT;
            r_wait    <= w_wait_load;
            r_win_idx <= '0;
            r_win_vld <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Display-side outputs trail the state register by one clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      number       <= C_MAX;
      mode         <= 3'd0;
      winner       <= 3'd0;
      winner_valid <= 1'b0;
      new_best     <= 1'b0;
    end else begin
      mode         <= r_state;
      winner       <= r_win_idx;
      winner_valid <= r_win_vld;
      new_best     <= r_nb_pend;
      case (r_state)
        S_IDLE:  number <= r_best;
        S_WAIT:  number <= 14'd0;
        S_GO:    number <= r_react_cnt;
        S_DONE:  number <= r_result;
        default: number <= C_MAX;
      endcase
    end
  end

endmodule
`default_nettype wire
